// File: rtl/uart_pkg.sv
// Shared UART framing constants and receiver state encoding.
package uart_pkg;

  localparam int   UART_FRAME_BITS = 11;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RESET_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_recv.sv
// UART receiver: 8E1 frames sampled mid-bit, bytes packed into a word with a valid/clear handshake.
module uart_recv
  import uart_pkg::*;
#(
  parameter int PACKET_SIZE  = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [PACKET_SIZE-1:0] packet,
  output logic                   packet_valid,
  input  logic                   packet_clear,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int NUM_BYTES = PACKET_SIZE / UART_DATA_BITS;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t              state_q, state_d;
  logic                        rx_s, rx_prev_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        par_q, par_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PACKET_SIZE-1:0]      packet_q, packet_d;
  logic                        valid_q, valid_d;
  logic                        parity_err_q, parity_err_d;
  logic                        frame_err_q, frame_err_d;
  logic                        overrun_q, overrun_d;
  logic                        end_hit, fall_edge;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign end_hit   = (cnt_q == CNT_END);
  assign fall_edge = rx_prev_q && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall_edge) state_d = START;
      // A line that is no longer low at mid-start was a glitch.
      START:   if (cnt_q == CNT_MID) state_d = (rx_s == UART_START_BIT) ? DATA : IDLE;
      DATA:    if (end_hit && bit_idx_q == BIT_LAST) state_d = PARITY;
      PARITY:  if (end_hit) state_d = STOP;
      STOP:    if (end_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    idx_d        = idx_q;
    packet_d     = packet_q;
    valid_d      = valid_q && !packet_clear;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    unique case (state_q)
      IDLE: cnt_d = '0;
      START: if (cnt_q == CNT_MID) begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      DATA: if (end_hit) begin
        cnt_d     = '0;
        shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + 1'b1;
      end
      PARITY: if (end_hit) begin
        cnt_d = '0;
        par_d = rx_s;
      end
      STOP: if (end_hit) begin
        cnt_d = '0;
        if (rx_s != UART_STOP_BIT) begin
          frame_err_d = 1'b1;
        end else if (par_q != ^shift_q) begin
          parity_err_d = 1'b1;
        end else if (!valid_q || packet_clear) begin
          packet_d[UART_DATA_BITS*int'(idx_q) +: UART_DATA_BITS] = shift_q;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // NOTE: the packet word is plain state, not a RAM, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      idx_q        <= '0;
      packet_q     <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_prev_q    <= rx_s;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      idx_q        <= idx_d;
      packet_q     <= packet_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign packet       = packet_q;
  assign packet_valid = valid_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed and randomized frames checked against a byte-level packet model.
module tb_uart_recv;

  localparam int CPB      = 4;
  localparam int PS       = 16;
  localparam int NB       = PS / 8;
  localparam int FRAME_CY = 11 * CPB;
  localparam int STOP_CY  = FRAME_CY + 1;
  localparam int SLOT_CY  = FRAME_CY + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          packet_clear = 1'b0;
  logic [PS-1:0] packet;
  logic          packet_valid, parity_err, frame_err, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [PS-1:0] m_pkt;
  int            m_idx;
  logic          m_valid;

  int fe_cnt, pe_cnt, ov_cnt, fe_at, pe_at, ov_at, vrise_at;

  uart_recv #(.PACKET_SIZE(PS), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .packet       (packet),
    .packet_valid (packet_valid),
    .packet_clear (packet_clear),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt   = '0;
    m_idx   = 0;
    m_valid = 1'b0;
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  task automatic clear_stats();
    fe_cnt = 0; pe_cnt = 0; ov_cnt = 0;
    fe_at = -1; pe_at = -1; ov_at = -1; vrise_at = -1;
  endtask

  task automatic sample_outputs(input int c, inout logic prev_valid);
    if (frame_err)  begin fe_cnt++; if (fe_at < 0) fe_at = c; end
    if (parity_err) begin pe_cnt++; if (pe_at < 0) pe_at = c; end
    if (overrun)    begin ov_cnt++; if (ov_at < 0) ov_at = c; end
    if (packet_valid && !prev_valid && vrise_at < 0) vrise_at = c;
    prev_valid = packet_valid;
  endtask

  // Cycle c is counted from the posedge after which the start bit is driven.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic clr_at_stop);
    logic [10:0] bits;
    logic        prev_valid;
    bits       = {stop, par, data, 1'b0};
    prev_valid = packet_valid;
    clear_stats();
    for (int c = 0; c < SLOT_CY; c++) begin
      @(posedge clk); #1;
      rx           = (c < FRAME_CY) ? bits[c / CPB] : 1'b1;
      packet_clear = clr_at_stop && (c == FRAME_CY);
      @(negedge clk);
      sample_outputs(c, prev_valid);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] data, input logic par,
                       input logic stop, input logic clr);
    logic exp_fe, exp_pe, exp_ov, good, done;
    exp_fe = !stop;
    exp_pe = stop && (par != even_par(data));
    good   = stop && !exp_pe;
    exp_ov = good && m_valid && !clr;
    done   = 1'b0;
    if (good && !exp_ov) begin
      m_pkt[8*m_idx +: 8] = data;
      m_idx++;
      if (m_idx == NB) begin
        m_idx = 0;
        done  = 1'b1;
      end
    end
    if (clr)  m_valid = 1'b0;
    if (done) m_valid = 1'b1;
    send_frame(data, par, stop, clr);
    check({tag, ".fe_cnt"}, fe_cnt, exp_fe ? 1 : 0);
    check({tag, ".fe_at"},  fe_at,  exp_fe ? STOP_CY : -1);
    check({tag, ".pe_cnt"}, pe_cnt, exp_pe ? 1 : 0);
    check({tag, ".pe_at"},  pe_at,  exp_pe ? STOP_CY : -1);
    check({tag, ".ov_cnt"}, ov_cnt, exp_ov ? 1 : 0);
    check({tag, ".ov_at"},  ov_at,  exp_ov ? STOP_CY : -1);
    check({tag, ".vrise"},  vrise_at, done ? STOP_CY : -1);
    check({tag, ".packet"}, 32'(packet), 32'(m_pkt));
    check({tag, ".valid"},  32'(packet_valid), 32'(m_valid));
  endtask

  task automatic clear_pulse(input string tag);
    @(posedge clk); #1 packet_clear = 1'b1;
    @(posedge clk); #1 packet_clear = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    check({tag, ".valid"}, 32'(packet_valid), 32'(m_valid));
    check({tag, ".packet"}, 32'(packet), 32'(m_pkt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".packet"}, 32'(packet), 0);
    check({tag, ".flags"}, {28'd0, packet_valid, parity_err, frame_err, overrun}, 0);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [10:0] bits;
    logic        prev_valid;
    int          r, s;

    model_reset();
    #1 check_all_zero("reset_hold");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("reset_idle");

    frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    frame("3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    check("pkt_3ca5", 32'(packet), 32'h3CA5);
    clear_pulse("clr1");

    frame("01_badpar", 8'h01, 1'b0, 1'b1, 1'b0);
    frame("01_goodpar", 8'h01, 1'b1, 1'b1, 1'b0);
    frame("55_badstop", 8'h55, 1'b0, 1'b0, 1'b0);

    prev_valid = packet_valid;
    clear_stats();
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      sample_outputs(c, prev_valid);
      @(posedge clk);
    end
    @(negedge clk);
    check("glitch.pulses", fe_cnt + pe_cnt + ov_cnt, 0);
    check("glitch.packet", 32'(packet), 32'(m_pkt));
    check("glitch.valid", 32'(packet_valid), 32'(m_valid));

    frame("12_complete", 8'h12, even_par(8'h12), 1'b1, 1'b0);
    frame("77_overrun", 8'h77, even_par(8'h77), 1'b1, 1'b0);
    frame("88_clr_at_stop", 8'h88, even_par(8'h88), 1'b1, 1'b1);
    check("pkt_1288", 32'(packet), 32'h1288);

    bits = {1'b1, even_par(8'hFF), 8'hFF, 1'b0};
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1 rx = bits[c / CPB];
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_frame");
    rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("reset_release");
    frame("5a", 8'h5A, even_par(8'h5A), 1'b1, 1'b0);
    frame("c3", 8'hC3, even_par(8'hC3), 1'b1, 1'b0);
    check("pkt_c35a", 32'(packet), 32'hC35A);

    for (int k = 0; k < 24; k++) begin
      rd = 8'($urandom);
      r  = $urandom_range(0, 7);
      s  = $urandom_range(0, 3);
      if (s == 0) clear_pulse($sformatf("rnd%0d.clr", k));
      frame($sformatf("rnd%0d", k), rd, even_par(rd) ^ (r == 1), r != 0, s == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
